// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage
// Execute-to-writeback stage behind the 32-bit ALU. ALU results are captured
// with their destination tag into a 2-entry in-order buffer and drained to a
// shared register-file write port that may stall. Retirement updates the
// architectural Z/N/V flags, a sticky overflow flag and a retire counter.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_*              ALU result handshake (in_valid/in_ready) and payload
//   rf_we/waddr/wdata register-file write request from the head entry
//   rf_ready          register file accepts the write this cycle
//   flag_z/n/v        architectural flags, flag_v_sticky sticky overflow
//   clr_sticky        clears the sticky overflow (a same-cycle set wins)
//   q_rd / q_hit      RAW hazard lookup against buffered entries
//   retire_cnt        wrapping count of retired results
module alu_writeback_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_zero,
  input  logic                  in_neg,
  input  logic                  in_ovf,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_wen,
  input  logic                  in_setf,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  input  logic                  rf_ready,
  output logic                  flag_z,
  output logic                  flag_n,
  output logic                  flag_v,
  output logic                  flag_v_sticky,
  input  logic                  clr_sticky,
  input  logic [REG_ADDR_W-1:0] q_rd,
  output logic                  q_hit,
  output logic [CNT_W-1:0]      retire_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0]     data;
    logic                  zero;
    logic                  neg;
    logic                  ovf;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wen;
    logic                  setf;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t           state_reg, state_next;
  entry_t           fifo_reg [2];
  logic             head_reg, tail_reg;
  entry_t           head;
  logic             head_valid;
  logic             accept, retire;
  logic             z_reg, n_reg, v_reg, sticky_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       slot_hit;

  assign head       = fifo_reg[head_reg];
  assign head_valid = (state_reg != EMPTY);
  assign accept     = in_valid && in_ready;
  // Non-writing entries and r0 targets never need the port, so they drain
  // even while the register file is stalled.
  assign retire     = head_valid && (rf_ready || !rf_we);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= EMPTY;
    else     state_reg <= state_next;
  end

  // Next-state logic on occupancy
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      EMPTY: if (accept) state_next = ONE;
      ONE: begin
        if (accept && !retire)      state_next = FULL;
        else if (retire && !accept) state_next = EMPTY;
      end
      FULL:    if (retire) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  // Outputs: in_ready depends only on registered state, never on rf_ready.
  always_comb begin
    in_ready = (state_reg != FULL);
    rf_we    = head_valid && head.wen && (head.rd != '0);
    rf_waddr = head_valid ? head.rd   : '0;
    rf_wdata = head_valid ? head.data : '0;
  end

  // Payload storage; no reset needed because validity comes from the state.
  always_ff @(posedge clk) begin
    if (accept) fifo_reg[tail_reg] <= '{in_data, in_zero, in_neg, in_ovf, in_rd, in_wen, in_setf};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg <= 1'b0;
      tail_reg <= 1'b0;
    end else begin
      if (accept) tail_reg <= ~tail_reg;
      if (retire) head_reg <= ~head_reg;
    end
  end

  // Architectural flags, sticky overflow and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      z_reg      <= 1'b0;
      n_reg      <= 1'b0;
      v_reg      <= 1'b0;
      sticky_reg <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      if (retire && head.setf) begin
        z_reg <= head.zero;
        n_reg <= head.neg;
        v_reg <= head.ovf;
      end
      // A retiring overflow takes priority over a same-cycle clear.
      if (retire && head.setf && head.ovf) sticky_reg <= 1'b1;
      else if (clr_sticky)                 sticky_reg <= 1'b0;
      if (retire) cnt_reg <= cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign flag_z        = z_reg;
  assign flag_n        = n_reg;
  assign flag_v        = v_reg;
  assign flag_v_sticky = sticky_reg;
  assign retire_cnt    = cnt_reg;

  // Hazard lookup: slot gi holds a live entry when the buffer is full, or
  // when it holds one entry and gi is the head slot.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_hit
      logic slot_valid;
      assign slot_valid = (state_reg == FULL) ||
                          ((state_reg == ONE) && (head_reg == 1'(gi)));
      assign slot_hit[gi] = slot_valid && fifo_reg[gi].wen &&
                            (fifo_reg[gi].rd == q_rd) && (q_rd != '0);
    end
  endgenerate

  assign q_hit = |slot_hit;

endmodule
